// File: rtl/wa_wr_buffer_if.sv
// Interface bundling the sif write strobe side and the target replay side
// of wa_wr_buffer, plus its level/overflow status signals.
interface wa_wr_buffer_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic              wa_wr_s;
    logic [ADDR_W-1:0] wa_addr;
    logic [DATA_W-1:0] wa_data_wr;
    logic              tgt_valid;
    logic [ADDR_W-1:0] tgt_addr;
    logic [DATA_W-1:0] tgt_data;
    logic              tgt_ready;
    logic [LW-1:0]     level;
    logic              ovf;
    logic              ovf_clr;

    modport slave (
        input  wa_wr_s, wa_addr, wa_data_wr, tgt_ready, ovf_clr,
        output tgt_valid, tgt_addr, tgt_data, level, ovf
    );

    modport master (
        output wa_wr_s, wa_addr, wa_data_wr, tgt_ready, ovf_clr,
        input  tgt_valid, tgt_addr, tgt_data, level, ovf
    );
endinterface

// File: rtl/wa_wr_buffer.sv
// Write-post FIFO behind sif: absorbs write strobes, replays them over
// valid/ready, flags drops. Optional: WA_WR_BUFFER_COALESCE_EN merges writes.
module wa_wr_buffer #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    wa_wr_buffer_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [ADDR_W-1:0] addr_mem_q [DEPTH];
    logic [DATA_W-1:0] data_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;

    logic valid, pop, full, push, drop, coal;

`ifdef WA_WR_BUFFER_COALESCE_EN
    logic [PW-1:0] newest;
    assign newest = wr_ptr_q - 1'b1;
    // Merge into the newest entry when it targets the same address and
    // is not leaving the FIFO this cycle.
    always_comb begin
        coal = 1'b0;
        if (bus.wa_wr_s && level_q != '0 &&
            addr_mem_q[newest] == bus.wa_addr &&
            (level_q > LW'(1) || !pop))
            coal = 1'b1;
    end
`else
    assign coal = 1'b0;
`endif

    // Handshake decode and next-state for pointers, level and overflow.
    always_comb begin
        valid    = (level_q != '0);
        pop      = valid & bus.tgt_ready;
        full     = (level_q == LW'(DEPTH));
        push     = bus.wa_wr_s & ~coal & (~full | pop);
        drop     = bus.wa_wr_s & ~coal & full & ~pop;
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        ovf_d = ovf_q;
        if (drop)
            ovf_d = 1'b1;
        else if (bus.ovf_clr)
            ovf_d = 1'b0;
    end

    // Control state; reset discards all held entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage array is left unreset; only written on accept or merge.
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= bus.wa_addr;
            data_mem_q[wr_ptr_q] <= bus.wa_data_wr;
        end
`ifdef WA_WR_BUFFER_COALESCE_EN
        else if (coal) begin
            data_mem_q[newest] <= bus.wa_data_wr;
        end
`endif
    end

    // Head is forced to zero while empty so outputs are clean after reset.
    assign bus.tgt_valid = valid;
    assign bus.tgt_addr  = valid ? addr_mem_q[rd_ptr_q] : '0;
    assign bus.tgt_data  = valid ? data_mem_q[rd_ptr_q] : '0;
    assign bus.level     = level_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_wa_wr_buffer.sv
// Directed bench for wa_wr_buffer: scoreboard queue of expected replays
// checked by an independent monitor, plus direct level/ovf checks.
module tb_wa_wr_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    wa_wr_buffer_if #(.ADDR_W(8), .DATA_W(16), .DEPTH(8)) bus ();

    wa_wr_buffer #(.ADDR_W(8), .DATA_W(16), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic [23:0] sb [$];

    task automatic check(input string nm, input int act, input int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted head must match the oldest expected entry.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && bus.tgt_valid && bus.tgt_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_pop", 1, 0);
                end else begin
                    check("pop_addr", int'(bus.tgt_addr), int'(sb[0][23:16]));
                    check("pop_data", int'(bus.tgt_data), int'(sb[0][15:0]));
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [7:0] a, input logic [15:0] d, input bit exp);
        bus.wa_wr_s    = 1'b1;
        bus.wa_addr    = a;
        bus.wa_data_wr = d;
        if (exp) sb.push_back({a, d});
        tick();
        bus.wa_wr_s = 1'b0;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        bus.tgt_ready = 1'b1;
        while (bus.level != 0 && n < 40) begin
            tick();
            n++;
        end
        check({nm, "_level0"}, int'(bus.level), 0);
        check({nm, "_sb_empty"}, sb.size(), 0);
        bus.tgt_ready = 1'b0;
    endtask

    initial begin
        bus.wa_wr_s    = 1'b0;
        bus.wa_addr    = '0;
        bus.wa_data_wr = '0;
        bus.tgt_ready  = 1'b0;
        bus.ovf_clr    = 1'b0;
        #1;
        check("rst_valid", int'(bus.tgt_valid), 0);
        check("rst_level", int'(bus.level), 0);
        check("rst_ovf", int'(bus.ovf), 0);
        check("rst_addr", int'(bus.tgt_addr), 0);
        check("rst_data", int'(bus.tgt_data), 0);
        tick();
        rst = 1'b0;
        tick();

        // Single write, one-cycle latency, immediate acceptance.
        bus.tgt_ready = 1'b1;
        check("single_pre_level", int'(bus.level), 0);
        strobe(8'h12, 16'hBEEF, 1'b1);
        check("single_valid", int'(bus.tgt_valid), 1);
        check("single_level1", int'(bus.level), 1);
        tick();
        check("single_valid_off", int'(bus.tgt_valid), 0);
        check("single_level0", int'(bus.level), 0);
        bus.tgt_ready = 1'b0;

        // Fill past capacity: ninth write dropped, ovf set.
        for (int i = 0; i < 9; i++)
            strobe(8'(i), 16'(16'h0100 + i), i < 8);
        check("fill_level", int'(bus.level), 8);
        check("fill_ovf", int'(bus.ovf), 1);
        check("fill_head", int'(bus.tgt_addr), 0);
        drain("fill");
        check("fill_ovf_sticky", int'(bus.ovf), 1);
        bus.ovf_clr = 1'b1;
        tick();
        bus.ovf_clr = 1'b0;
        check("fill_ovf_clr", int'(bus.ovf), 0);

        // Full with simultaneous pop: write accepted, lands last.
        for (int i = 0; i < 8; i++)
            strobe(8'(8'h40 + i), 16'(16'h0200 + i), 1'b1);
        bus.tgt_ready = 1'b1;
        strobe(8'h55, 16'h5555, 1'b1);
        check("fullpop_level", int'(bus.level), 8);
        check("fullpop_ovf", int'(bus.ovf), 0);
        drain("fullpop");

        // Backpressure: head held stable.
        strobe(8'h30, 16'h1234, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(bus.tgt_valid), 1);
            check("hold_addr", int'(bus.tgt_addr), 'h30);
            check("hold_data", int'(bus.tgt_data), 'h1234);
            tick();
        end
        drain("hold");

        // Overflow and clear in the same cycle: set wins.
        for (int i = 0; i < 8; i++)
            strobe(8'(8'h60 + i), 16'(16'h0300 + i), 1'b1);
        check("ovfclr_pre", int'(bus.ovf), 0);
        bus.ovf_clr = 1'b1;
        strobe(8'h99, 16'h9999, 1'b0);
        check("ovfclr_setwins", int'(bus.ovf), 1);
        check("ovfclr_level", int'(bus.level), 8);
        tick();
        bus.ovf_clr = 1'b0;
        check("ovfclr_cleared", int'(bus.ovf), 0);

        // Reset at level 5 clears immediately.
        bus.tgt_ready = 1'b1;
        tick();
        tick();
        tick();
        bus.tgt_ready = 1'b0;
        check("prerst_level", int'(bus.level), 5);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_valid", int'(bus.tgt_valid), 0);
        check("midrst_level", int'(bus.level), 0);
        sb.delete();
        tick();
        rst = 1'b0;
        tick();
        strobe(8'hA5, 16'hCAFE, 1'b1);
        check("postrst_valid", int'(bus.tgt_valid), 1);
        drain("postrst");

        // Two writes to the same address while stalled.
        bus.wa_wr_s    = 1'b1;
        bus.wa_addr    = 8'h04;
        bus.wa_data_wr = 16'h0001;
        tick();
        bus.wa_data_wr = 16'h0002;
        tick();
        bus.wa_wr_s = 1'b0;
`ifdef WA_WR_BUFFER_COALESCE_EN
        sb.push_back({8'h04, 16'h0002});
        check("coal_level", int'(bus.level), 1);
        check("coal_data", int'(bus.tgt_data), 2);
`else
        sb.push_back({8'h04, 16'h0001});
        sb.push_back({8'h04, 16'h0002});
        check("nocoal_level", int'(bus.level), 2);
        check("nocoal_data", int'(bus.tgt_data), 1);
`endif
        drain("coal");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
